// File: rtl/wb_pkg.sv
// wb_pkg: shared size encodings, store-entry layout and occupancy width for the commit unit
package wb_pkg;
    typedef enum logic [1:0] {SZ_8 = 2'd0, SZ_16 = 2'd1, SZ_32 = 2'd2, SZ_64 = 2'd3} sz_e;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 64;
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
        sz_e                   size;
    } sq_entry_t;
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/wb_commit_unit_if.sv
// wb_commit_unit_if: store-queue head to data-cache write port, valid/ready handshake
interface wb_commit_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 64);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic [1:0]        mem_req_size;
    modport master (output mem_req_valid, mem_req_addr, mem_req_data, mem_req_size, input mem_req_ready);
    modport slave (input mem_req_valid, mem_req_addr, mem_req_data, mem_req_size, output mem_req_ready);
endinterface

// File: rtl/wb_store_queue.sv
// wb_store_queue: circular FIFO taking up to NUM_CH compacted pushes and one pop per cycle
module wb_store_queue
    import wb_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  DEPTH  = 8,
    parameter type entry_t = sq_entry_t,
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       push_mask,
    input  entry_t [NUM_CH-1:0]     push_data,
    input  logic                    pop,
    output logic [CW-1:0]           count,
    output entry_t                  head
);
    localparam int PW = $clog2(DEPTH);
    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] ofs [NUM_CH];
    logic [CW-1:0] n_push;
    // each pushing channel lands at wr_ptr plus the number of pushing channels below it
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ofs[i] = n_push[PW-1:0];
            n_push = n_push + CW'(push_mask[i]);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push[PW-1:0];
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + n_push - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (push_mask[i]) mem[wr_ptr + ofs[i]] <= push_data[i];
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback/commit gating, atomic store-queue push and fault/interrupt qualification
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 64,
    parameter int  ADDR_W = 32,
    parameter int  IDX_W  = 3,
    parameter int  DEPTH  = 8,
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    output logic                     stall,
    input  logic [NUM_CH*DATA_W-1:0] res_data,
    input  logic [NUM_CH*ADDR_W-1:0] res_dest,
    input  logic [NUM_CH-1:0]        res_isReg,
    input  logic [NUM_CH-1:0]        res_isSeg,
    input  logic [NUM_CH-1:0]        res_isMem,
    input  logic [NUM_CH-1:0]        res_wb,
    input  logic [1:0]               res_size,
    input  logic                     IE_in,
    input  logic                     interrupt_in,
    output logic [NUM_CH-1:0]        reg_ld,
    output logic [NUM_CH-1:0]        seg_ld,
    output logic [NUM_CH*IDX_W-1:0]  reg_addr,
    output logic [NUM_CH*DATA_W-1:0] wr_data,
    wb_commit_unit_if.master         mem,
    output logic [CW-1:0]            sq_count,
    output logic                     final_IE_val,
    output logic                     valid_out
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        sz_e               size;
    } entry_t;
    logic [NUM_CH-1:0]  mem_ch;
    logic [CW-1:0]      n_mem, free;
    logic               accept, commit;
    entry_t [NUM_CH-1:0] ent;
    entry_t             head;
    assign mem_ch = res_isMem & res_wb;
    always_comb begin
        n_mem = '0;
        for (int i = 0; i < NUM_CH; i++) n_mem = n_mem + CW'(mem_ch[i]);
    end
    // free space uses the registered count only, keeping mem_req_ready off the stall path
    assign free         = CW'(DEPTH) - sq_count;
    assign stall        = valid_in & ~rst & (n_mem > free);
    assign accept       = valid_in & ~stall & ~rst;
    assign commit       = accept & ~IE_in;
    assign valid_out    = accept;
    assign final_IE_val = accept & (IE_in | interrupt_in);
    assign reg_ld       = {NUM_CH{commit}} & res_isReg & res_wb;
    assign seg_ld       = {NUM_CH{commit}} & res_isSeg & res_wb;
    assign wr_data      = res_data;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign reg_addr[i*IDX_W +: IDX_W] = res_dest[i*ADDR_W +: IDX_W];
        assign ent[i] = '{addr: res_dest[i*ADDR_W +: ADDR_W], data: res_data[i*DATA_W +: DATA_W], size: sz_e'(res_size)};
    end
    assign mem.mem_req_valid = sq_count != '0;
    assign mem.mem_req_addr  = head.addr;
    assign mem.mem_req_data  = head.data;
    assign mem.mem_req_size  = head.size;
    wb_store_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .entry_t(entry_t)) u_sq (
        .clk       (clk),
        .rst       (rst),
        .push_mask (mem_ch & {NUM_CH{commit}}),
        .push_data (ent),
        .pop       (mem.mem_req_valid & mem.mem_req_ready),
        .count     (sq_count),
        .head      (head)
    );
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: directed scoreboard bench for wb_commit_unit
module tb_wb_commit_unit;
    logic         clk = 1'b0;
    logic         rst, valid_in, IE_in, interrupt_in;
    logic [255:0] res_data;
    logic [127:0] res_dest;
    logic [3:0]   res_isReg, res_isSeg, res_isMem, res_wb;
    logic [1:0]   res_size;
    logic         stall, final_IE_val, valid_out;
    logic [3:0]   reg_ld, seg_ld, sq_count;
    logic [11:0]  reg_addr;
    logic [255:0] wr_data;
    int           n_cmp = 0, n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
        logic [1:0]  s;
    } exp_t;
    exp_t sb [$];

    wb_commit_unit_if mem ();

    wb_commit_unit dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
        .res_data(res_data), .res_dest(res_dest), .res_isReg(res_isReg),
        .res_isSeg(res_isSeg), .res_isMem(res_isMem), .res_wb(res_wb),
        .res_size(res_size), .IE_in(IE_in), .interrupt_in(interrupt_in),
        .reg_ld(reg_ld), .seg_ld(seg_ld), .reg_addr(reg_addr), .wr_data(wr_data),
        .mem(mem), .sq_count(sq_count), .final_IE_val(final_IE_val), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        valid_in = 0; IE_in = 0; interrupt_in = 0;
        res_data = '0; res_dest = '0; res_size = 2'd3;
        res_isReg = '0; res_isSeg = '0; res_isMem = '0; res_wb = '0;
    endtask

    // kind: 0 none, 1 reg, 2 seg, 3 mem, 4 reg without wb
    task automatic set_ch(input int i, input int kind, input logic [31:0] dest, input logic [63:0] data);
        res_dest[i*32 +: 32] = dest;
        res_data[i*64 +: 64] = data;
        res_isReg[i] = (kind == 1) || (kind == 4);
        res_isSeg[i] = (kind == 2);
        res_isMem[i] = (kind == 3);
        res_wb[i]    = (kind >= 1) && (kind <= 3);
        valid_in = 1;
    endtask

    task automatic push_sb(input logic [31:0] a, input logic [63:0] d);
        exp_t e;
        e.a = a; e.d = d; e.s = res_size;
        sb.push_back(e);
    endtask

    // negedge sample point; any handshake seen here is checked against the scoreboard head
    task automatic half();
        exp_t e;
        @(negedge clk);
        if (mem.mem_req_valid && mem.mem_req_ready) begin
            if (sb.size() == 0) chk("drain_unexpected", mem.mem_req_valid, 0);
            else begin
                e = sb.pop_front();
                chk("drain_addr", mem.mem_req_addr, e.a);
                chk("drain_data", mem.mem_req_data, e.d);
                chk("drain_size", mem.mem_req_size, e.s);
            end
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; mem.mem_req_ready = 0; clr();
        repeat (2) @(posedge clk);
        #1;
        half();
        chk("rst_count", sq_count, 0);
        chk("rst_valid", mem.mem_req_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_reg_ld", reg_ld, 0);
        chk("rst_ie", final_IE_val, 0);
        edge_();
        rst = 0;
        // register and segment writes, wb gating on channel 3
        mem.mem_req_ready = 1;
        set_ch(0, 1, 32'd3, 64'h11);
        set_ch(1, 2, 32'd7, 64'h22);
        set_ch(2, 1, 32'd5, 64'h33);
        set_ch(3, 4, 32'd6, 64'h44);
        half();
        chk("t1_reg_ld", reg_ld, 4'b0101);
        chk("t1_seg_ld", seg_ld, 4'b0010);
        chk("t1_addr0", reg_addr[2:0], 3);
        chk("t1_addr2", reg_addr[8:6], 5);
        chk("t1_wr_data", wr_data[191:128], 64'h33);
        chk("t1_valid_out", valid_out, 1);
        edge_();
        clr();
        half();
        chk("t1_count", sq_count, 0);
        edge_();
        // two stores with ready low, then drain
        mem.mem_req_ready = 0;
        set_ch(1, 3, 32'h1000, 64'hAAAA_0000_0000_000A);
        set_ch(3, 3, 32'h2000, 64'hBBBB_0000_0000_000B);
        push_sb(32'h1000, 64'hAAAA_0000_0000_000A);
        push_sb(32'h2000, 64'hBBBB_0000_0000_000B);
        half();
        chk("t2_accept", valid_out, 1);
        chk("t2_latency", mem.mem_req_valid, 0);
        edge_();
        clr();
        half();
        chk("t2_count", sq_count, 2);
        chk("t2_valid", mem.mem_req_valid, 1);
        chk("t2_head_addr", mem.mem_req_addr, 32'h1000);
        chk("t2_head_data", mem.mem_req_data, 64'hAAAA_0000_0000_000A);
        edge_();
        half();
        chk("t2_hold_addr", mem.mem_req_addr, 32'h1000);
        edge_();
        mem.mem_req_ready = 1;
        half(); edge_();
        half(); edge_();
        mem.mem_req_ready = 0;
        half();
        chk("t2_empty_count", sq_count, 0);
        chk("t2_empty_valid", mem.mem_req_valid, 0);
        edge_();
        // fill to 6, then a three-store instruction must stall
        for (int i = 0; i < 4; i++) begin
            set_ch(i, 3, 32'h100 + i, 64'hC0 + i);
            push_sb(32'h100 + i, 64'hC0 + i);
        end
        half(); edge_();
        clr();
        for (int i = 0; i < 2; i++) begin
            set_ch(i, 3, 32'h104 + i, 64'hC4 + i);
            push_sb(32'h104 + i, 64'hC4 + i);
        end
        half(); edge_();
        clr();
        half();
        chk("t3_count6", sq_count, 6);
        edge_();
        set_ch(0, 3, 32'h200, 64'hD0);
        set_ch(1, 3, 32'h201, 64'hD1);
        set_ch(2, 1, 32'd1, 64'hD2);
        set_ch(3, 3, 32'h202, 64'hD3);
        half();
        chk("t3_stall", stall, 1);
        chk("t3_no_accept", valid_out, 0);
        chk("t3_no_reg_ld", reg_ld, 0);
        edge_();
        mem.mem_req_ready = 1;
        half();
        chk("t3_stall_pop", stall, 1);
        edge_();
        mem.mem_req_ready = 0;
        half();
        chk("t3_unstall", stall, 0);
        chk("t3_accept", valid_out, 1);
        chk("t3_reg_ld", reg_ld, 4'b0100);
        push_sb(32'h200, 64'hD0);
        push_sb(32'h201, 64'hD1);
        push_sb(32'h202, 64'hD3);
        edge_();
        clr();
        half();
        chk("t3_count8", sq_count, 8);
        edge_();
        set_ch(0, 3, 32'h2FF, 64'hEE);
        half();
        chk("t3_full_stall", stall, 1);
        edge_();
        clr();
        // count 7: one store accepted with a same-cycle pop; two stores stall
        mem.mem_req_ready = 1;
        half(); edge_();
        set_ch(0, 3, 32'h300, 64'hF0);
        half();
        chk("t4_free1_stall", stall, 0);
        chk("t4_free1_accept", valid_out, 1);
        push_sb(32'h300, 64'hF0);
        edge_();
        clr();
        set_ch(0, 3, 32'h301, 64'hF1);
        set_ch(1, 3, 32'h302, 64'hF2);
        half();
        chk("t4_count7", sq_count, 7);
        chk("t4_two_stall", stall, 1);
        chk("t4_two_no_accept", valid_out, 0);
        edge_();
        clr();
        mem.mem_req_ready = 0;
        // faulting instruction commits nothing; interrupt commits
        set_ch(0, 1, 32'd4, 64'h1);
        set_ch(1, 3, 32'h500, 64'h2);
        IE_in = 1;
        half();
        chk("t5_ie_final", final_IE_val, 1);
        chk("t5_ie_reg_ld", reg_ld, 0);
        edge_();
        clr();
        half();
        chk("t5_ie_no_push", sq_count, 6);
        edge_();
        set_ch(0, 1, 32'd2, 64'h3);
        set_ch(1, 3, 32'h600, 64'h4);
        interrupt_in = 1;
        half();
        chk("t5_int_final", final_IE_val, 1);
        chk("t5_int_reg_ld", reg_ld, 4'b0001);
        push_sb(32'h600, 64'h4);
        edge_();
        clr();
        half();
        chk("t5_int_push", sq_count, 7);
        edge_();
        // reset mid-drain discards the queue
        mem.mem_req_ready = 1;
        half(); edge_();
        half(); edge_();
        mem.mem_req_ready = 0;
        rst = 1;
        half();
        chk("t6_pre_rst_count", sq_count, 5);
        edge_();
        rst = 0;
        sb.delete();
        half();
        chk("t6_rst_count", sq_count, 0);
        chk("t6_rst_valid", mem.mem_req_valid, 0);
        edge_();
        res_size = 2'd1;
        set_ch(2, 3, 32'h700, 64'h77);
        push_sb(32'h700, 64'h77);
        half(); edge_();
        clr();
        half();
        chk("t6_post_count", sq_count, 1);
        chk("t6_post_addr", mem.mem_req_addr, 32'h700);
        edge_();
        mem.mem_req_ready = 1;
        half(); edge_();
        mem.mem_req_ready = 0;
        half();
        chk("t6_post_empty", sq_count, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
